// File: rtl/sc_cpu_pkg.sv
// rtl/sc_cpu_pkg.sv - RV32I opcodes, funct3 codes, ALU/immediate enums and immediate builder
package sc_cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_t fmt);
        case (fmt)
            IMM_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm_gen = {ins[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_gen = 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/sc_alu.sv
// rtl/sc_alu.sv - combinational RV32I integer ALU
module sc_alu
    import sc_cpu_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  alu_op_t     op_i,
    output logic [31:0] result_o
);

    always_comb begin
        result_o = a_i + b_i;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << b_i[4:0];
            ALU_SLT:  result_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'd0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> b_i[4:0];
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = a_i + b_i;
        endcase
    end

endmodule

// File: rtl/sc_cpu.sv
// rtl/sc_cpu.sv - single-cycle RV32I core with internal instruction ROM and data RAM
module sc_cpu
    import sc_cpu_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter              IMEM_FILE  = "",
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cycles_consumed,
    output logic        clkout
);

    localparam int IW = $clog2(IMEM_WORDS);
    localparam int DW = $clog2(DMEM_WORDS);

    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf_q [32];

    initial begin
        for (int i = 0; i < IMEM_WORDS; i++) imem[i] = 32'd0;
        for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = 32'd0;
    end

    logic [31:0] pc_q, pc_d;
    logic [31:0] cycles_q, cycles_d;
    logic        halted_q, halted_d;

    logic [31:0] instr, imm, rs1_val, rs2_val, alu_b, alu_res, pc_plus4;
    logic [31:0] load_word, load_shift, load_val, store_data, rd_val;
    logic [15:0] load_half;
    logic [3:0]  store_be;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [IW-1:0] imem_idx;
    logic [DW-1:0] dmem_idx;
    logic        rd_we, mem_we, halt, taken;
    imm_fmt_t    imm_fmt;
    alu_op_t     alu_op;

    assign imem_idx = IW'({2'b00, pc_q[31:2]} % IMEM_WORDS);
    assign instr    = imem[imem_idx];
    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign f3       = instr[14:12];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        imm_fmt = IMM_I;
        case (opcode)
            OP_STORE:         imm_fmt = IMM_S;
            OP_BRANCH:        imm_fmt = IMM_B;
            OP_LUI, OP_AUIPC: imm_fmt = IMM_U;
            OP_JAL:           imm_fmt = IMM_J;
            default:          imm_fmt = IMM_I;
        endcase
    end

    assign imm = imm_gen(instr, imm_fmt);

    // funct7[5] only selects SUB on register ops; on OP_IMM it is part of the immediate.
    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OP_IMM || opcode == OP_REG) begin
            case (f3)
                F3_ADD:  alu_op = (opcode == OP_REG && instr[30]) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = instr[30] ? ALU_SRA : ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

    assign alu_b = (opcode == OP_REG) ? rs2_val : imm;

    sc_alu u_alu (
        .a_i      (rs1_val),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res)
    );

    // Load/store address is the ALU sum; misaligned accesses fall back to lane selection.
    assign dmem_idx   = DW'({2'b00, alu_res[31:2]} % DMEM_WORDS);
    assign load_word  = dmem[dmem_idx];
    assign load_shift = load_word >> {alu_res[1:0], 3'b000};
    assign load_half  = alu_res[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        load_val = load_word;
        case (f3)
            F3_LB:   load_val = {{24{load_shift[7]}}, load_shift[7:0]};
            F3_LH:   load_val = {{16{load_half[15]}}, load_half};
            F3_LBU:  load_val = {24'd0, load_shift[7:0]};
            F3_LHU:  load_val = {16'd0, load_half};
            default: load_val = load_word;
        endcase
    end

    always_comb begin
        store_data = rs2_val;
        store_be   = 4'b1111;
        case (f3)
            F3_SB: begin
                store_data = {4{rs2_val[7:0]}};
                store_be   = 4'b0001 << alu_res[1:0];
            end
            F3_SH: begin
                store_data = {2{rs2_val[15:0]}};
                store_be   = alu_res[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                store_data = rs2_val;
                store_be   = 4'b1111;
            end
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (f3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val < rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d   = pc_plus4;
        rd_we  = 1'b0;
        rd_val = alu_res;
        mem_we = 1'b0;
        halt   = 1'b0;
        case (opcode)
            OP_LUI:    begin rd_we = 1'b1; rd_val = imm; end
            OP_AUIPC:  begin rd_we = 1'b1; rd_val = pc_q + imm; end
            OP_JAL:    begin rd_we = 1'b1; rd_val = pc_plus4; pc_d = pc_q + imm; end
            OP_JALR:   begin rd_we = 1'b1; rd_val = pc_plus4; pc_d = alu_res & ~32'd1; end
            OP_BRANCH: if (taken) pc_d = pc_q + imm;
            OP_LOAD:   begin rd_we = 1'b1; rd_val = load_val; end
            OP_STORE:  mem_we = 1'b1;
            OP_IMM,
            OP_REG:    rd_we = 1'b1;
            OP_SYSTEM: begin halt = 1'b1; pc_d = pc_q; end
            default:   pc_d = pc_plus4;
        endcase
    end

    assign cycles_d = cycles_q + 32'd1;
    assign halted_d = halted_q | halt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            cycles_q <= 32'd0;
            halted_q <= 1'b0;
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (!halted_q) begin
            pc_q     <= pc_d;
            cycles_q <= cycles_d;
            halted_q <= halted_d;
            if (rd_we && rd != 5'd0) rf_q[rd] <= rd_val;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !halted_q && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (store_be[b]) dmem[dmem_idx][b*8 +: 8] <= store_data[b*8 +: 8];
            end
        end
    end

    assign cycles_consumed = cycles_q;
    assign clkout          = clk & ~halted_q;

endmodule

// File: tb/tb_sc_cpu.sv
// tb/tb_sc_cpu.sv - directed-program bench for the single-cycle RV32I core
module tb_sc_cpu;

    logic        clk;
    logic        rst;
    logic [31:0] cycles_consumed;
    logic        clkout;

    int passed;
    int total;

    sc_cpu dut (
        .clk             (clk),
        .rst             (rst),
        .cycles_consumed (cycles_consumed),
        .clkout          (clkout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) dut.imem[i] = 32'd0;
    endtask

    task automatic release_and_run(input int n);
        @(negedge clk);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_imem();
        #1;
        total++; if (cycles_consumed !== 32'd0) $display("FAIL reset_cycles got %h exp %h", cycles_consumed, 32'd0); else passed++;
        total++; if (dut.pc_q !== 32'd0) $display("FAIL reset_pc got %h exp %h", dut.pc_q, 32'd0); else passed++;
        @(posedge clk); #1;
        total++; if (clkout !== 1'b1) $display("FAIL reset_clkout got %b exp %b", clkout, 1'b1); else passed++;
    endtask

    task automatic test_arith();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'h00500093;
        dut.imem[1] = 32'h00700113;
        dut.imem[2] = 32'h002081B3;
        dut.imem[3] = 32'h00000073;
        release_and_run(10);
        total++; if (dut.rf_q[3] !== 32'd12) $display("FAIL arith_x3 got %h exp %h", dut.rf_q[3], 32'd12); else passed++;
        total++; if (cycles_consumed !== 32'd4) $display("FAIL arith_cycles got %0d exp %0d", cycles_consumed, 4); else passed++;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++; if (clkout !== 1'b0) $display("FAIL halt_clkout_%0d got %b exp %b", k, clkout, 1'b0); else passed++;
        end
        total++; if (cycles_consumed !== 32'd4) $display("FAIL halt_frozen got %0d exp %0d", cycles_consumed, 4); else passed++;
    endtask

    task automatic load_loop();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'h00A00093;
        dut.imem[1] = 32'hFFF08093;
        dut.imem[2] = 32'hFE009EE3;
        dut.imem[3] = 32'h00000073;
    endtask

    task automatic test_loop();
        load_loop();
        release_and_run(40);
        total++; if (dut.rf_q[1] !== 32'd0) $display("FAIL loop_x1 got %h exp %h", dut.rf_q[1], 32'd0); else passed++;
        total++; if (cycles_consumed !== 32'd22) $display("FAIL loop_cycles got %0d exp %0d", cycles_consumed, 22); else passed++;
    endtask

    task automatic test_memory();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'hFFF00093;
        dut.imem[1] = 32'h00102023;
        dut.imem[2] = 32'h00100103;
        dut.imem[3] = 32'h00104183;
        dut.imem[4] = 32'h00205203;
        dut.imem[5] = 32'h00000023;
        dut.imem[6] = 32'h00002283;
        dut.imem[7] = 32'h00000073;
        release_and_run(12);
        total++; if (dut.rf_q[2] !== 32'hFFFFFFFF) $display("FAIL mem_lb got %h exp %h", dut.rf_q[2], 32'hFFFFFFFF); else passed++;
        total++; if (dut.rf_q[3] !== 32'h000000FF) $display("FAIL mem_lbu got %h exp %h", dut.rf_q[3], 32'h000000FF); else passed++;
        total++; if (dut.rf_q[4] !== 32'h0000FFFF) $display("FAIL mem_lhu got %h exp %h", dut.rf_q[4], 32'h0000FFFF); else passed++;
        total++; if (dut.rf_q[5] !== 32'hFFFFFF00) $display("FAIL mem_lw_after_sb got %h exp %h", dut.rf_q[5], 32'hFFFFFF00); else passed++;
        total++; if (cycles_consumed !== 32'd8) $display("FAIL mem_cycles got %0d exp %0d", cycles_consumed, 8); else passed++;
    endtask

    task automatic test_jumps();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'h008000EF;
        dut.imem[1] = 32'h00100493;
        dut.imem[2] = 32'h00300167;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (dut.rf_q[1] !== 32'd4) $display("FAIL jal_link got %h exp %h", dut.rf_q[1], 32'd4); else passed++;
        total++; if (dut.pc_q !== 32'd8) $display("FAIL jal_pc got %h exp %h", dut.pc_q, 32'd8); else passed++;
        @(posedge clk); #1;
        total++; if (dut.pc_q !== 32'd2) $display("FAIL jalr_pc got %h exp %h", dut.pc_q, 32'd2); else passed++;
        total++; if (dut.rf_q[2] !== 32'd12) $display("FAIL jalr_link got %h exp %h", dut.rf_q[2], 32'd12); else passed++;
        total++; if (dut.rf_q[9] !== 32'd0) $display("FAIL jal_skipped got %h exp %h", dut.rf_q[9], 32'd0); else passed++;
    endtask

    task automatic test_upper_imm();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'h123452B7;
        dut.imem[1] = 32'h00C0006F;
        dut.imem[4] = 32'h00001317;
        dut.imem[5] = 32'h00000073;
        release_and_run(8);
        total++; if (dut.rf_q[5] !== 32'h12345000) $display("FAIL lui got %h exp %h", dut.rf_q[5], 32'h12345000); else passed++;
        total++; if (dut.rf_q[6] !== 32'h00001010) $display("FAIL auipc got %h exp %h", dut.rf_q[6], 32'h00001010); else passed++;
        total++; if (cycles_consumed !== 32'd4) $display("FAIL upper_cycles got %0d exp %0d", cycles_consumed, 4); else passed++;
    endtask

    task automatic test_alu_ops();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'hFF800093;
        dut.imem[1] = 32'h4010D113;
        dut.imem[2] = 32'h001031B3;
        dut.imem[3] = 32'h40100233;
        dut.imem[4] = 32'h00000073;
        release_and_run(8);
        total++; if (dut.rf_q[2] !== 32'hFFFFFFFC) $display("FAIL srai got %h exp %h", dut.rf_q[2], 32'hFFFFFFFC); else passed++;
        total++; if (dut.rf_q[3] !== 32'd1) $display("FAIL sltu got %h exp %h", dut.rf_q[3], 32'd1); else passed++;
        total++; if (dut.rf_q[4] !== 32'd8) $display("FAIL sub got %h exp %h", dut.rf_q[4], 32'd8); else passed++;
        total++; if (cycles_consumed !== 32'd5) $display("FAIL alu_cycles got %0d exp %0d", cycles_consumed, 5); else passed++;
    endtask

    task automatic test_x0();
        rst = 1'b1;
        clear_imem();
        dut.imem[0] = 32'h00500013;
        dut.imem[1] = 32'h00000073;
        release_and_run(5);
        total++; if (dut.rf_q[0] !== 32'd0) $display("FAIL x0_write got %h exp %h", dut.rf_q[0], 32'd0); else passed++;
        total++; if (cycles_consumed !== 32'd2) $display("FAIL x0_cycles got %0d exp %0d", cycles_consumed, 2); else passed++;
    endtask

    task automatic test_reset_mid_loop();
        load_loop();
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++; if (cycles_consumed !== 32'd0) $display("FAIL midrst_cycles got %0d exp %0d", cycles_consumed, 0); else passed++;
        total++; if (dut.pc_q !== 32'd0) $display("FAIL midrst_pc got %h exp %h", dut.pc_q, 32'd0); else passed++;
        total++; if (dut.rf_q[1] !== 32'd0) $display("FAIL midrst_x1 got %h exp %h", dut.rf_q[1], 32'd0); else passed++;
        release_and_run(40);
        total++; if (dut.rf_q[1] !== 32'd0) $display("FAIL rerun_x1 got %h exp %h", dut.rf_q[1], 32'd0); else passed++;
        total++; if (cycles_consumed !== 32'd22) $display("FAIL rerun_cycles got %0d exp %0d", cycles_consumed, 22); else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        test_reset();
        test_arith();
        test_loop();
        test_memory();
        test_jumps();
        test_upper_imm();
        test_alu_ops();
        test_x0();
        test_reset_mid_loop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
